// File: rtl/match_lock_tracker_if.sv
// Comparator-result stream into the lock tracker, plus its status outputs.
// No timing of its own: plain wires between stimulus and tracker.
// No backpressure: the tracker accepts one sample every cycle.
interface match_lock_tracker_if #(
    parameter int TOTAL_W = 8
);
    logic               in_valid;
    logic               match;
    logic [3:0]         in_data;
    logic               clear;
    logic               locked;
    logic               lock_pulse;
    logic               loss_pulse;
    logic [3:0]         streak;
    logic [3:0]         lock_value;
    logic [TOTAL_W-1:0] match_total;

    modport master (
        output in_valid, match, in_data, clear,
        input  locked, lock_pulse, loss_pulse, streak, lock_value, match_total
    );

    modport slave (
        input  in_valid, match, in_data, clear,
        output locked, lock_pulse, loss_pulse, streak, lock_value, match_total
    );
endinterface

// File: rtl/match_lock_tracker.sv
// Declares lock after LOCK_COUNT consecutive valid matches, drops it after UNLOCK_COUNT misses.
// Latency: all outputs registered, a sample at edge N is visible after edge N.
// No backpressure: every valid sample is consumed, clear overrides the sample.
module match_lock_tracker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 2,
    parameter int TOTAL_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    match_lock_tracker_if.slave   bus
);
    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [3:0]         hit_q, hit_d;
    logic [3:0]         miss_q, miss_d;
    logic [3:0]         streak_q, streak_d;
    logic [3:0]         lock_value_q, lock_value_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               lock_pulse_q, lock_pulse_d;
    logic               loss_pulse_q, loss_pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            hit_q        <= '0;
            miss_q       <= '0;
            streak_q     <= '0;
            lock_value_q <= '0;
            total_q      <= '0;
            lock_pulse_q <= 1'b0;
            loss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            streak_q     <= streak_d;
            lock_value_q <= lock_value_d;
            total_q      <= total_d;
            lock_pulse_q <= lock_pulse_d;
            loss_pulse_q <= loss_pulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        streak_d     = streak_q;
        lock_value_d = lock_value_q;
        total_d      = total_q;
        lock_pulse_d = 1'b0;
        loss_pulse_d = 1'b0;

        // Clear wins over the sample; lock_value is deliberately kept.
        if (bus.clear) begin
            state_d  = SEARCH;
            hit_d    = '0;
            miss_d   = '0;
            streak_d = '0;
            total_d  = '0;
        end else if (bus.in_valid) begin
            if (bus.match) begin
                if (streak_q != 4'hF)
                    streak_d = streak_q + 4'd1;
                if (total_q != {TOTAL_W{1'b1}})
                    total_d = total_q + TOTAL_W'(1);
            end else begin
                streak_d = '0;
            end

            case (state_q)
                SEARCH: begin
                    if (bus.match) begin
                        if (hit_q + 4'd1 == 4'(LOCK_COUNT)) begin
                            state_d      = LOCKED;
                            lock_pulse_d = 1'b1;
                            lock_value_d = bus.in_data;
                            hit_d        = '0;
                            miss_d       = '0;
                        end else begin
                            hit_d = hit_q + 4'd1;
                        end
                    end else begin
                        hit_d = '0;
                    end
                end
                LOCKED: begin
                    if (bus.match) begin
                        miss_d = '0;
                    end else if (miss_q + 4'd1 == 4'(UNLOCK_COUNT)) begin
                        state_d      = SEARCH;
                        loss_pulse_d = 1'b1;
                        miss_d       = '0;
                        hit_d        = '0;
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    assign bus.locked      = (state_q == LOCKED);
    assign bus.lock_pulse  = lock_pulse_q;
    assign bus.loss_pulse  = loss_pulse_q;
    assign bus.streak      = streak_q;
    assign bus.lock_value  = lock_value_q;
    assign bus.match_total = total_q;
endmodule

// File: tb/tb_match_lock_tracker.sv
// Bench for match_lock_tracker: directed scenarios plus random traffic against a reference model.
// Outputs are compared with the model at every falling edge once checking is enabled.
module tb_match_lock_tracker;
    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 2;
    localparam int TOTAL_W      = 8;
    localparam int TOTAL_MAX    = (1 << TOTAL_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    match_lock_tracker_if #(.TOTAL_W(TOTAL_W)) bus ();

    match_lock_tracker #(
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT),
        .TOTAL_W     (TOTAL_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Reference model: integer run lengths and a boolean lock flag.
    bit         m_locked = 0;
    bit         m_lock_pulse = 0;
    bit         m_loss_pulse = 0;
    int         m_run = 0;
    int         m_miss = 0;
    int         m_streak = 0;
    int         m_total = 0;
    logic [3:0] m_lock_value = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked = 0; m_lock_pulse = 0; m_loss_pulse = 0;
            m_run = 0; m_miss = 0; m_streak = 0; m_total = 0;
            m_lock_value = '0;
        end else begin
            m_lock_pulse = 0;
            m_loss_pulse = 0;
            if (bus.clear) begin
                m_locked = 0; m_run = 0; m_miss = 0; m_streak = 0; m_total = 0;
            end else if (bus.in_valid) begin
                if (bus.match) begin
                    m_streak = (m_streak < 15) ? m_streak + 1 : 15;
                    m_total  = (m_total < TOTAL_MAX) ? m_total + 1 : TOTAL_MAX;
                    if (!m_locked) begin
                        m_run++;
                        if (m_run == LOCK_COUNT) begin
                            m_locked = 1; m_lock_pulse = 1;
                            m_lock_value = bus.in_data;
                            m_run = 0; m_miss = 0;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end else begin
                    m_streak = 0;
                    if (!m_locked) begin
                        m_run = 0;
                    end else begin
                        m_miss++;
                        if (m_miss == UNLOCK_COUNT) begin
                            m_locked = 0; m_loss_pulse = 1;
                            m_miss = 0; m_run = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",      32'(bus.locked),      32'(m_locked));
            check("lock_pulse",  32'(bus.lock_pulse),  32'(m_lock_pulse));
            check("loss_pulse",  32'(bus.loss_pulse),  32'(m_loss_pulse));
            check("streak",      32'(bus.streak),      32'(m_streak));
            check("lock_value",  32'(bus.lock_value),  32'(m_lock_value));
            check("match_total", 32'(bus.match_total), 32'(m_total));
        end
    end

    task automatic step(input bit v, input bit m, input logic [3:0] d, input bit c);
        bus.in_valid = v;
        bus.match    = m;
        bus.in_data  = d;
        bus.clear    = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.match = 1'b0; bus.in_data = '0; bus.clear = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        step(0, 0, 4'h0, 0);
        check("reset_locked", 32'(bus.locked), 32'd0);
        check("reset_total",  32'(bus.match_total), 32'd0);

        // Four matches lock on 4'hA.
        for (int i = 0; i < 4; i++) step(1, 1, 4'hA, 0);
        check("t1_lock_pulse", 32'(bus.lock_pulse), 32'd1);
        check("t1_locked",     32'(bus.locked), 32'd1);
        check("t1_lock_value", 32'(bus.lock_value), 32'hA);
        check("t1_streak",     32'(bus.streak), 32'd4);
        check("t1_total",      32'(bus.match_total), 32'd4);
        step(0, 0, 4'h0, 0);
        check("t1_pulse_drop", 32'(bus.lock_pulse), 32'd0);

        // Isolated misses are forgiven, two in a row unlock.
        step(1, 0, 4'h1, 0); check("t3_hold_a", 32'(bus.locked), 32'd1);
        step(1, 1, 4'h2, 0); check("t3_hold_b", 32'(bus.locked), 32'd1);
        step(1, 0, 4'h3, 0); check("t3_hold_c", 32'(bus.locked), 32'd1);
        step(1, 1, 4'h4, 0);
        step(1, 0, 4'h5, 0); check("t3_hold_d", 32'(bus.locked), 32'd1);
        step(1, 0, 4'h6, 0);
        check("t3_loss_pulse", 32'(bus.loss_pulse), 32'd1);
        check("t3_unlocked",   32'(bus.locked), 32'd0);
        check("t3_lock_value", 32'(bus.lock_value), 32'hA);
        step(0, 0, 4'h0, 0);
        check("t3_loss_drop", 32'(bus.loss_pulse), 32'd0);

        // A mismatch restarts the hit run.
        step(0, 0, 4'h0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 4'h5, 0);
        check("t2_no_lock", 32'(bus.locked), 32'd0);
        check("t2_streak3", 32'(bus.streak), 32'd3);
        step(1, 0, 4'h5, 0);
        check("t2_streak0", 32'(bus.streak), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 4'h5, 0);
        check("t2_still_search", 32'(bus.locked), 32'd0);
        step(1, 1, 4'h7, 0);
        check("t2_lock_pulse", 32'(bus.lock_pulse), 32'd1);
        check("t2_lock_value", 32'(bus.lock_value), 32'h7);
        check("t2_total",      32'(bus.match_total), 32'd7);

        // Gaps between valid samples do not break the run.
        step(0, 0, 4'h0, 1);
        for (int i = 0; i < 8; i++) begin
            step(i % 2 == 0, 1, 4'h9, 0);
            if (i == 6) check("t4_lock_pulse", 32'(bus.lock_pulse), 32'd1);
        end
        check("t4_locked", 32'(bus.locked), 32'd1);

        // Saturation of streak and total.
        step(0, 0, 4'h0, 1);
        for (int i = 0; i < 300; i++) step(1, 1, 4'h3, 0);
        check("sat_streak", 32'(bus.streak), 32'd15);
        check("sat_total",  32'(bus.match_total), 32'd255);

        // Clear while locked, with a mismatch sample in the same cycle.
        step(1, 0, 4'hE, 1);
        check("clr_locked", 32'(bus.locked), 32'd0);
        check("clr_loss",   32'(bus.loss_pulse), 32'd0);
        check("clr_total",  32'(bus.match_total), 32'd0);
        check("clr_streak", 32'(bus.streak), 32'd0);
        check("clr_value",  32'(bus.lock_value), 32'h3);

        // Asynchronous reset in the middle of a cycle while locked.
        for (int i = 0; i < 4; i++) step(1, 1, 4'hC, 0);
        step(0, 0, 4'h0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_locked", 32'(bus.locked), 32'd0);
        check("arst_total",  32'(bus.match_total), 32'd0);
        check("arst_pulses", 32'({bus.lock_pulse, bus.loss_pulse}), 32'd0);
        check("arst_value",  32'(bus.lock_value), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 1, 4'hB, 0);
        check("relock_pulse", 32'(bus.lock_pulse), 32'd1);
        check("relock_value", 32'(bus.lock_value), 32'hB);

        // Random traffic, biased towards matches so lock and loss both occur.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(3) != 0, $urandom_range(9) < 7,
                 4'($urandom_range(15)), $urandom_range(99) == 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/match_lock_tracker.md
Name: match_lock_tracker

Overview:
- Downstream consumer of the 4-bit equality comparator's `match` output.
- Takes a valid-qualified stream of match results plus the compared nibble, and declares "lock" after LOCK_COUNT consecutive matches.
- Drops lock after UNLOCK_COUNT consecutive mismatches.
- Reports lock/loss events, the current match streak, the nibble captured at lock, and a saturating match total.

Parameters:
- LOCK_COUNT, 4, consecutive valid matches needed to enter LOCKED; legal range 1..15.
- UNLOCK_COUNT, 2, consecutive valid mismatches needed to leave LOCKED; legal range 1..15.
- TOTAL_W, 8, width of the saturating match-total counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  current cycle carries a comparator result.
- match  input  1  comparator result (1 = data_a equals data_b); ignored when in_valid=0.
- in_data  input  4  nibble that was compared (data_a side); ignored when in_valid=0.
- clear  input  1  synchronous soft clear; has priority over in_valid.
- locked  output  1  1 while in LOCKED.
- lock_pulse  output  1  one-cycle pulse on SEARCH->LOCKED.
- loss_pulse  output  1  one-cycle pulse on LOCKED->SEARCH via mismatches.
- streak  output  4  consecutive valid matches, saturating at 15.
- lock_value  output  4  in_data of the sample that completed lock.
- match_total  output  TOTAL_W  count of valid matches, saturating at all-ones.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=SEARCH.
  - hit_cnt, miss_cnt, streak, lock_value, match_total = 0.
  - locked, lock_pulse, loss_pulse = 0.
- All outputs are registered. A sample presented with in_valid=1 at edge N is reflected in outputs after edge N (1-cycle latency).
- in_valid=0 cycles:
  - no state or counter change.
  - lock_pulse and loss_pulse return to 0.
  - gaps do not break a streak.
- lock_pulse and loss_pulse default to 0 every cycle unless set by a transition below.
- streak on a valid sample: match=1 -> min(streak+1, 15); match=0 -> 0. Applies in both states.
- match_total: +1 on each valid match, holds at 2^TOTAL_W-1.
- SEARCH state:
  - valid match: hit_cnt+1.
  - If the match brings hit_cnt to LOCK_COUNT: next state LOCKED, locked=1, lock_pulse=1, lock_value<=in_data, hit_cnt=0, miss_cnt=0.
  - valid mismatch: hit_cnt=0.
- LOCKED state:
  - valid match: miss_cnt=0; lock_value unchanged.
  - valid mismatch: miss_cnt+1.
  - If the mismatch brings miss_cnt to UNLOCK_COUNT: next state SEARCH, locked=0, loss_pulse=1, miss_cnt=0, hit_cnt=0.
  - lock_value holds its last value after loss.
- Boundary cases:
  - LOCK_COUNT=1: the first valid match locks.
  - UNLOCK_COUNT=1: the first valid mismatch unlocks.
- clear=1 (synchronous, any state, regardless of in_valid):
  - state=SEARCH; hit_cnt, miss_cnt, streak, match_total = 0; locked=0.
  - No loss_pulse. The sample in that cycle is discarded. lock_value is retained.
- Reset asserted mid-operation: all state and outputs return to reset values immediately, with no pulse emitted. Operation resumes on the first edge after rst_n rises.
- No X propagation: match and in_data are don't-care when in_valid=0.

Test Plan:
- Reset then 4 valid matches with in_data=4'hA -> lock_pulse=1 for one cycle after the 4th edge; locked=1; lock_value=4'hA; streak=4; match_total=4.
- Matches M,M,M, mismatch, then M,M,M,M -> no lock after the first three; streak=0 after the mismatch; lock occurs only on the 8th sample; match_total=7.
- Locked, then mismatch, match, mismatch -> locked stays 1 throughout (miss_cnt resets). Follow with mismatch, mismatch -> loss_pulse=1 for one cycle; locked=0; lock_value still 4'hA.
- Matches with in_valid toggling 1,0,1,0,... (4 valid matches spread over 8 cycles) -> lock after the 4th valid sample. Separately, 300 valid matches -> streak=15, match_total=255, both saturated.
- While locked, assert clear together with in_valid=1, match=0 -> locked=0; loss_pulse=0; match_total=0; streak=0; lock_value retained.
- Assert rst_n=0 mid-lock between clock edges -> locked=0 and match_total=0 immediately, without waiting for an edge; no pulses. After release, 4 matches relock.
